// File: rtl/brom_loader.sv
// Boot-ROM image loader: streams 256 bytes into boot RAM, holds the CPU in reset until the image is complete.
// Define BROM_CHECKSUM_EN to require a trailing checksum byte after the image.
module brom_loader #(
    parameter logic [15:0] IDLE_TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        ram_we,
    output logic [7:0]  ram_a,
    output logic [7:0]  ram_d,
    input  logic [15:0] bus_a,
    input  logic        bus_wr,
    input  logic [7:0]  bus_din,
    output logic        done,
    output logic        cpu_rst_n,
    output logic        brom_en,
    output logic [1:0]  err
);

    typedef enum logic [1:0] {LOAD, CSUM, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;
    logic        s_ready_q, done_q, brom_en_q;
    logic        xfer, waiting, tmo;
    logic [7:0]  sum_c;

    // s_ready lags the state by one edge, so the DONE cycle must be masked here
    assign xfer = s_valid && s_ready_q && (state_q != DONE);
`ifdef BROM_CHECKSUM_EN
    assign waiting = (state_q == LOAD && idx_q != 8'd0) || state_q == CSUM;
`else
    assign waiting = state_q == LOAD && idx_q != 8'd0;
`endif
    assign tmo   = waiting && !xfer && (cnt_q == IDLE_TIMEOUT - 16'd1);
    assign sum_c = sum_q + s_data;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (xfer) begin
            cnt_d = 16'd0;
            case (state_q)
                LOAD: begin
                    idx_d = idx_q + 8'd1;
                    sum_d = sum_c;
                    if (idx_q == 8'hFF) begin
`ifdef BROM_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
`ifdef BROM_CHECKSUM_EN
                CSUM: begin
                    if (sum_c == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        err_d[0] = 1'b1;
                        sum_d    = 8'd0;
                        idx_d    = 8'd0;
                        state_d  = LOAD;
                    end
                end
`endif
                default: ;
            endcase
        end else if (tmo) begin
            err_d[1] = 1'b1;
            idx_d    = 8'd0;
            sum_d    = 8'd0;
            cnt_d    = 16'd0;
            state_d  = LOAD;
        end else if (waiting) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            idx_q     <= 8'd0;
            sum_q     <= 8'd0;
            cnt_q     <= 16'd0;
            err_q     <= 2'b00;
            s_ready_q <= 1'b0;
            done_q    <= 1'b0;
            brom_en_q <= 1'b1;
            ram_we    <= 1'b0;
            ram_a     <= 8'd0;
            ram_d     <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            s_ready_q <= state_q != DONE;
            done_q    <= state_q == DONE;
            ram_we    <= xfer && state_q == LOAD;
            if (xfer && state_q == LOAD) begin
                ram_a <= idx_q;
                ram_d <= s_data;
            end
            if (bus_wr && bus_a == 16'hFF50 && bus_din != 8'd0 && done_q)
                brom_en_q <= 1'b0;
        end
    end

    assign s_ready   = s_ready_q;
    assign done      = done_q;
    assign cpu_rst_n = done_q;
    assign brom_en   = brom_en_q;
    assign err       = err_q;

endmodule

// File: tb/tb_brom_loader.sv
// Randomized scoreboard bench for brom_loader.
// Define BROM_CHECKSUM_EN to exercise the checksum build.
module tb_brom_loader;

    localparam logic [15:0] T = 16'd200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        ram_we;
    logic [7:0]  ram_a, ram_d;
    logic [15:0] bus_a = 16'd0;
    logic        bus_wr = 1'b0;
    logic [7:0]  bus_din = 8'd0;
    logic        done, cpu_rst_n, brom_en;
    logic [1:0]  err;

    brom_loader #(.IDLE_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d),
        .bus_a(bus_a), .bus_wr(bus_wr), .bus_din(bus_din),
        .done(done), .cpu_rst_n(cpu_rst_n), .brom_en(brom_en), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t expq[$];
    wr_t mon_e;

    int checks = 0;
    int fails = 0;
    int pos = 0;
    int sum = 0;
    logic [1:0] exp_err = 2'b00;
    bit img_done = 0;
    bit gaps = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ram_we) begin
            checks++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL ram_write unexpected a=%0h d=%0h", ram_a, ram_d);
            end else begin
                mon_e = expq.pop_front();
                if (ram_a !== mon_e.a || ram_d !== mon_e.d) begin
                    fails++;
                    $display("FAIL ram_write actual a=%0h d=%0h required a=%0h d=%0h",
                             ram_a, ram_d, mon_e.a, mon_e.d);
                end
            end
        end
    end

    // Reference: 256 data bytes land at addresses 0..255, then (optionally) one checksum byte.
    task automatic model_accept(input logic [7:0] b);
        if (pos < 256) begin
            expq.push_back(wr_t'{a: pos[7:0], d: b});
            pos++;
            sum = (sum + int'(b)) % 256;
`ifndef BROM_CHECKSUM_EN
            if (pos == 256) img_done = 1;
`endif
        end else begin
            if ((sum + int'(b)) % 256 == 0) img_done = 1;
            else exp_err[0] = 1'b1;
            pos = 0;
            sum = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        bit r;
        if (gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        forever begin
            r = s_ready;
            @(posedge clk);
            if (r) break;
            n++;
            if (n > 20) begin
                checks++;
                fails++;
                $display("FAIL s_ready_wait actual=0 required=1");
                break;
            end
            @(negedge clk);
        end
        #1;
        if (r) model_accept(b);
        s_valid = 1'b0;
    endtask

    task automatic send_image(input bit rnd);
        for (int i = 0; i < 256; i++) begin
            if (rnd) send(8'($urandom));
            else send(8'(i));
        end
    endtask

`ifdef BROM_CHECKSUM_EN
    task automatic send_csum(input bit good);
        logic [7:0] c;
        c = 8'((256 - sum) % 256);
        if (!good) c = c ^ 8'h01;
        send(c);
    endtask
`endif

    task automatic check_end();
        chk("done_early", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("done", {31'd0, done}, {31'd0, img_done});
        chk("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, img_done});
        chk("s_ready_end", {31'd0, s_ready}, {31'd0, !img_done});
        chk("err", {30'd0, err}, {30'd0, exp_err});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        expq.delete();
        pos = 0;
        sum = 0;
        exp_err = 2'b00;
        img_done = 0;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_a", {24'd0, ram_a}, 32'd0);
        chk("rst_ram_d", {24'd0, ram_d}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_brom_en", {31'd0, brom_en}, 32'd1);
        chk("rst_err", {30'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_post_rst", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic exp_en);
        @(negedge clk);
        bus_a   = a;
        bus_din = d;
        bus_wr  = 1'b1;
        @(posedge clk);
        #1;
        bus_wr = 1'b0;
        chk("brom_en", {31'd0, brom_en}, {31'd0, exp_en});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        bus_write(16'hFF50, 8'h01, 1'b1);

        gaps = 0;
`ifdef BROM_CHECKSUM_EN
        send_image(0);
        send_csum(0);
        check_end();
`endif
        send_image(0);
`ifdef BROM_CHECKSUM_EN
        send_csum(1);
`endif
        check_end();

        bus_write(16'hFF50, 8'h00, 1'b1);
        bus_write(16'hFF51, 8'h01, 1'b1);
        bus_write(16'hFF50, 8'h01, 1'b0);
        bus_write(16'hFF50, 8'h00, 1'b0);

        do_reset();
        gaps = 1;
        for (int i = 0; i < 10; i++) send(8'($urandom));
        repeat (int'(T) - 1) @(posedge clk);
        #1;
        chk("timeout_early", {31'd0, err[1]}, 32'd0);
        @(posedge clk);
        #1;
        chk("timeout", {31'd0, err[1]}, 32'd1);
        pos = 0;
        sum = 0;
        exp_err[1] = 1'b1;
        send_image(1);
`ifdef BROM_CHECKSUM_EN
        send_csum(1);
`endif
        check_end();

        do_reset();
        for (int i = 0; i < 100; i++) send(8'($urandom));
        do_reset();
        send_image(1);
`ifdef BROM_CHECKSUM_EN
        send_csum(1);
`endif
        check_end();

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
